// File: rtl/iram_prog_loader.sv
// Streams host words into the IRAM program port: drains the AHB-lite bus, writes one word per accepted beat
// (1-cycle write latency), then releases the CPU; load_wready drops on abort or once len words are taken.
module iram_prog_loader #(
  parameter int ADDR_W         = 10,
  parameter int DRAIN_CYCLES   = 4,
  parameter int RELEASE_CYCLES = 2,
  parameter bit HOLD_AT_RESET  = 1'b0
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_wvalid,
  input  logic [31:0]       load_wdata,
  output logic              load_wready,
  input  logic              lite_mmc_hsel,
  output logic              prog_wen,
  output logic [15:0]       prog_waddr,
  output logic [31:0]       prog_wdata,
  output logic              cpu_hold,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_cnt,
  output logic [31:0]       load_csum
);

  typedef enum logic [2:0] {IDLE, DRAIN, LOAD, REL, HALT} state_t;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [ADDR_W+1:0] IRAM_WORDS = {2'b01, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [DW-1:0]     idle_cnt;
  logic [RW-1:0]     rel_cnt;

  logic [ADDR_W+1:0] start_end;
  logic              start_ok;
  logic              beat;
  logic              last_beat;
  logic [ADDR_W-1:0] wr_addr;

  // Range check is done one bit wider than len so base+len cannot overflow.
  assign start_end   = {2'b00, load_base} + {1'b0, load_len};
  assign start_ok    = (load_len != '0) && (start_end <= IRAM_WORDS);
  assign load_wready = (state == LOAD) && (load_cnt < len_q) && !load_abort;
  assign beat        = load_wvalid && load_wready;
  assign last_beat   = ((load_cnt + 1'b1) == len_q);
  assign wr_addr     = base_q + load_cnt[ADDR_W-1:0];
  assign load_busy   = (state == DRAIN) || (state == LOAD) || (state == REL);

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idle_cnt   <= '0;
      rel_cnt    <= '0;
      prog_wen   <= 1'b0;
      prog_waddr <= '0;
      prog_wdata <= '0;
      cpu_hold   <= HOLD_AT_RESET;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      load_cnt   <= '0;
      load_csum  <= '0;
    end else begin
      prog_wen  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (load_start) begin
            if (start_ok) begin
              base_q    <= load_base;
              len_q     <= load_len;
              load_cnt  <= '0;
              load_csum <= '0;
              idle_cnt  <= '0;
              cpu_hold  <= 1'b1;
              state     <= DRAIN;
            end else begin
              load_err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (load_abort) begin
            load_err <= 1'b1;
            state    <= HALT;
          end else if (lite_mmc_hsel) begin
            idle_cnt <= '0;
          end else if (idle_cnt == DW'(DRAIN_CYCLES - 1)) begin
            state <= LOAD;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        LOAD: begin
          // A write registered on the previous edge still appears this cycle.
          if (load_abort) begin
            load_err <= 1'b1;
            state    <= HALT;
          end else if (beat) begin
            prog_wen   <= 1'b1;
            prog_waddr <= 16'(wr_addr);
            prog_wdata <= load_wdata;
            load_cnt   <= load_cnt + 1'b1;
            load_csum  <= load_csum + load_wdata;
            if (last_beat) begin
              rel_cnt <= '0;
              state   <= REL;
            end
          end
        end
        REL: begin
          if (rel_cnt == RW'(RELEASE_CYCLES - 1)) begin
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
            state     <= IDLE;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iram_prog_loader.sv
// Bench for iram_prog_loader: directed load scenarios with random data, checked against a word-list model.
module tb_iram_prog_loader;

  localparam int DRAIN = 4;
  localparam int RELC  = 2;

  logic        clk = 1'b0;
  logic        pad_cpu_rst;
  logic        load_start, load_abort, load_wvalid, lite_mmc_hsel;
  logic [9:0]  load_base;
  logic [10:0] load_len;
  logic [31:0] load_wdata;
  logic        load_wready, prog_wen, cpu_hold, load_busy, load_done, load_err;
  logic [15:0] prog_waddr;
  logic [31:0] prog_wdata, load_csum;
  logic [10:0] load_cnt;

  logic        h_wready, h_wen, h_hold, h_busy, h_done, h_err;
  logic [15:0] h_waddr;
  logic [31:0] h_wdata, h_csum;
  logic [10:0] h_cnt;

  iram_prog_loader #(.ADDR_W(10), .DRAIN_CYCLES(DRAIN), .RELEASE_CYCLES(RELC), .HOLD_AT_RESET(1'b0)) u0 (
    .pll_core_cpuclk(clk), .pad_cpu_rst(pad_cpu_rst), .load_start(load_start), .load_abort(load_abort),
    .load_base(load_base), .load_len(load_len), .load_wvalid(load_wvalid), .load_wdata(load_wdata),
    .load_wready(load_wready), .lite_mmc_hsel(lite_mmc_hsel), .prog_wen(prog_wen), .prog_waddr(prog_waddr),
    .prog_wdata(prog_wdata), .cpu_hold(cpu_hold), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .load_cnt(load_cnt), .load_csum(load_csum));

  iram_prog_loader #(.ADDR_W(10), .DRAIN_CYCLES(DRAIN), .RELEASE_CYCLES(RELC), .HOLD_AT_RESET(1'b1)) u1 (
    .pll_core_cpuclk(clk), .pad_cpu_rst(pad_cpu_rst), .load_start(load_start), .load_abort(load_abort),
    .load_base(load_base), .load_len(load_len), .load_wvalid(load_wvalid), .load_wdata(load_wdata),
    .load_wready(h_wready), .lite_mmc_hsel(lite_mmc_hsel), .prog_wen(h_wen), .prog_waddr(h_waddr),
    .prog_wdata(h_wdata), .cpu_hold(h_hold), .load_busy(h_busy), .load_done(h_done),
    .load_err(h_err), .load_cnt(h_cnt), .load_csum(h_csum));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] stim[$];
  int          n_done, n_err, done_cyc, err_cyc, rise_cyc, fall_cyc;
  logic        hold_prev = 1'b0;
  int          total = 0;
  int          bad = 0;

  always @(negedge clk) begin
    if (prog_wen) wq.push_back('{prog_waddr, prog_wdata, cyc});
    if (load_done) begin n_done++; done_cyc = cyc; end
    if (load_err) begin n_err++; err_cyc = cyc; end
    if (cpu_hold && !hold_prev) rise_cyc = cyc;
    if (!cpu_hold && hold_prev) fall_cyc = cyc;
    hold_prev = cpu_hold;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back($urandom);
  endtask

  // abort_at < 0: full load; otherwise abort when abort_at words have been accepted.
  task automatic run_load(input logic [9:0] base, input logic [10:0] len, input int abort_at,
                          input bit bubbles, input int hmode);
    int          idx, guard, s, last_high, abort_cyc, exp_n;
    int          acc[$];
    logic [31:0] sum;
    logic [9:0]  a;
    logic        rdy_s, hold_before;
    bit          aborted;
    wq.delete(); n_done = 0; n_err = 0; acc.delete();
    last_high = -1; abort_cyc = -1; aborted = 0; sum = '0;
    exp_n = (abort_at >= 0) ? abort_at : int'(len);
    for (int i = 0; i < exp_n; i++) sum += stim[i];
    hold_before = cpu_hold;
    load_base = base; load_len = len; load_start = 1'b1; lite_mmc_hsel = 1'b0;
    s = cyc;
    tick();
    load_start = 1'b0;
    idx = 0; guard = 0;
    while (idx < int'(len) && !aborted && guard < 400) begin
      guard++;
      if (hmode == 1 && ((cyc - s) % 3 == 0) && (cyc - s) < 12) begin
        lite_mmc_hsel = 1'b1; last_high = cyc;
      end else begin
        lite_mmc_hsel = 1'b0;
      end
      load_wvalid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_wdata  = stim[idx];
      if (abort_at == idx) begin
        load_abort = 1'b1; load_wvalid = 1'b1; abort_cyc = cyc; aborted = 1;
      end
      @(negedge clk);
      rdy_s = load_wready;
      if (load_wvalid && rdy_s) begin acc.push_back(cyc); idx++; end
      tick();
      load_abort = 1'b0;
    end
    load_wvalid = 1'b0; lite_mmc_hsel = 1'b0;
    chk("send_guard", guard < 400, 1);
    if (aborted) tick(3);
    else for (int i = 0; i < 40 && n_done == 0 && n_err == 0; i++) tick();

    if (!hold_before) chk("hold_rise", rise_cyc, s + 1);
    chk("n_writes", wq.size(), exp_n);
    for (int i = 0; i < wq.size() && i < exp_n; i++) begin
      a = base + i[9:0];
      chk($sformatf("waddr[%0d]", i), wq[i].addr, {6'b0, a});
      chk($sformatf("wdata[%0d]", i), wq[i].data, stim[i]);
      if (i < acc.size()) chk($sformatf("wcyc[%0d]", i), wq[i].cyc, acc[i] + 1);
    end
    if (wq.size() > 0 && abort_at < 0 && !bubbles) begin
      if (hmode == 0) chk("first_wr_cyc", wq[0].cyc, s + DRAIN + 2);
      else            chk("drain_wr_cyc", wq[0].cyc, last_high + DRAIN + 2);
    end
    chk("load_cnt", load_cnt, exp_n);
    chk("load_csum", load_csum, sum);
    chk("busy_after", load_busy, 0);
    if (aborted) begin
      chk("abort_err_n", n_err, 1);
      chk("abort_err_cyc", err_cyc, abort_cyc + 1);
      chk("abort_done_n", n_done, 0);
      chk("abort_hold", cpu_hold, 1);
    end else begin
      chk("done_n", n_done, 1);
      chk("err_n", n_err, 0);
      if (wq.size() > 0) chk("done_cyc", done_cyc, wq[wq.size()-1].cyc + RELC);
      chk("hold_fall_cyc", fall_cyc, done_cyc);
      chk("hold_released", cpu_hold, 0);
    end
  endtask

  task automatic reject(input logic [9:0] base, input logic [10:0] len);
    logic hb;
    wq.delete(); n_err = 0; n_done = 0;
    hb = cpu_hold;
    load_base = base; load_len = len; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("rej_err_pulse", load_err, 1);
    tick(3);
    chk("rej_err_n", n_err, 1);
    chk("rej_writes", wq.size(), 0);
    chk("rej_hold", cpu_hold, hb);
    chk("rej_busy", load_busy, 0);
  endtask

  initial begin
    logic [9:0]  rb;
    logic [10:0] rl;
    int          maxl;
    pad_cpu_rst = 1'b1; load_start = 1'b0; load_abort = 1'b0; load_wvalid = 1'b0;
    lite_mmc_hsel = 1'b0; load_base = '0; load_len = '0; load_wdata = '0;
    tick(3);
    chk("reset_outs_hold0", {load_wready, prog_wen, prog_waddr, prog_wdata, cpu_hold, load_busy,
                             load_done, load_err, load_cnt, load_csum}, 0);
    chk("reset_hold1_cpu_hold", h_hold, 1);
    chk("reset_hold1_others", {h_wready, h_wen, h_waddr, h_wdata, h_busy, h_done, h_err, h_cnt, h_csum}, 0);
    pad_cpu_rst = 1'b0;
    tick();

    n_err = 0;
    load_abort = 1'b1; tick(); load_abort = 1'b0; tick(2);
    chk("idle_abort_ignored", n_err, 0);

    stim.delete();
    stim.push_back(32'h11111111); stim.push_back(32'h22222222);
    stim.push_back(32'h33333333); stim.push_back(32'h44444444);
    run_load(10'h010, 11'd4, -1, 1'b0, 0);
    chk("basic_csum", load_csum, 32'hAAAAAAAA);

    fill_random(3);
    run_load(10'h020, 11'd3, -1, 1'b0, 1);

    reject(10'h3FE, 11'd3);
    reject(10'h000, 11'd0);

    fill_random(2);
    run_load(10'h3FE, 11'd2, -1, 1'b1, 0);

    for (int k = 0; k < 3; k++) begin
      rb = 10'($urandom_range(0, 1023));
      maxl = 1024 - int'(rb);
      if (maxl > 16) maxl = 16;
      rl = 11'($urandom_range(1, maxl));
      fill_random(int'(rl));
      run_load(rb, rl, -1, 1'b1, 0);
    end

    fill_random(5);
    run_load(10'h100, 11'd5, 2, 1'b0, 0);
    fill_random(5);
    run_load(10'h100, 11'd5, -1, 1'b1, 0);

    fill_random(3);
    run_load(10'h200, 11'd3, 2, 1'b0, 0);
    reject(10'h3FF, 11'd2);
    fill_random(4);
    run_load(10'h050, 11'd4, 0, 1'b0, 0);
    fill_random(4);
    run_load(10'h050, 11'd4, -1, 1'b0, 0);

    fill_random(1);
    load_base = 10'h080; load_len = 11'd8; load_start = 1'b1;
    tick();
    load_start = 1'b0; load_wvalid = 1'b1; load_wdata = stim[0];
    tick(6);
    pad_cpu_rst = 1'b1;
    tick();
    wq.delete();
    tick();
    pad_cpu_rst = 1'b0;
    tick(4);
    chk("midrst_writes", wq.size(), 0);
    chk("midrst_state", {cpu_hold, load_busy, load_wready, load_cnt, load_csum}, 0);
    load_wvalid = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
